// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback arbiter: widths, link register
// and requester indices (JAL, load, ALU).
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int LINK_REG = 31;

    localparam int NUM_REQ  = 3;
    localparam int REQ_JAL  = 0;
    localparam int REQ_LD   = 1;
    localparam int REQ_ALU  = 2;

    localparam int STAT_W   = 16;

endpackage

// File: rtl/regfile_arb_age_ctr.sv
// Per-requester wait counter: counts cycles spent valid but ungranted, saturating
// at AGE_MAX; the saturated flag promotes the requester in arbitration.
module regfile_arb_age_ctr #(
    parameter int AGE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic granted,
    output logic saturated
);

    localparam int CW = (AGE_MAX < 2) ? 1 : $clog2(AGE_MAX + 1);
    localparam logic [CW-1:0] AGE_TOP = CW'(AGE_MAX);

    logic [CW-1:0] age;

    always_ff @(posedge clk) begin
        if (rst || !valid || granted) begin
            age <= '0;
        end else if (age != AGE_TOP) begin
            age <= age + 1'b1;
        end
    end

    assign saturated = (age == AGE_TOP);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port among JAL link, load and ALU
// writebacks. Optional wait statistics are enabled with REGFILE_ARB_STATS_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int LINK_REG = regfile_pkg::LINK_REG,
    parameter int AGE_MAX  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jal_valid,
    output logic              jal_ready,
    input  logic [DATA_W-1:0] jal_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              stall
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_jal_wait,
    output logic [STAT_W-1:0] stat_ld_wait,
    output logic [STAT_W-1:0] stat_alu_wait
`endif
);

    // Handshake: a request transfers in any cycle where valid && ready. The
    // requester keeps valid/addr/data stable until then; ready is a pure function
    // of the valids and ages, so it never changes within a cycle.

    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    logic [NUM_REQ-1:0] req_v;
    logic [NUM_REQ-1:0] req_sat;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    always_comb begin
        req_v          = '0;
        req_v[REQ_JAL] = jal_valid;
        req_v[REQ_LD]  = ld_valid;
        req_v[REQ_ALU] = alu_valid;
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
        regfile_arb_age_ctr #(.AGE_MAX(AGE_MAX)) u_age (
            .clk       (clk),
            .rst       (rst),
            .valid     (req_v[i]),
            .granted   (grant[i]),
            .saturated (req_sat[i])
        );
    end

    // Saturated requesters form their own class; base priority breaks ties within it.
    always_comb begin
        grant = '0;
        pick  = ((req_v & req_sat) != '0) ? (req_v & req_sat) : req_v;
        if (!rst) begin
            if (pick[REQ_JAL]) begin
                grant[REQ_JAL] = 1'b1;
            end else if (pick[REQ_LD]) begin
                grant[REQ_LD] = 1'b1;
            end else if (pick[REQ_ALU]) begin
                grant[REQ_ALU] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = alu_addr;
        sel_data = alu_data;
        if (grant[REQ_JAL]) begin
            sel_addr = LINK_ADDR;
            sel_data = jal_data;
        end else if (grant[REQ_LD]) begin
            sel_addr = ld_addr;
            sel_data = ld_data;
        end
    end

    assign jal_ready = grant[REQ_JAL];
    assign ld_ready  = grant[REQ_LD];
    assign alu_ready = grant[REQ_ALU];
    assign stall     = (req_v & ~grant) != '0;

    // Writes to r0 still consume the grant but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if (grant != '0) begin
                wr_en   <= (sel_addr != '0);
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

`ifdef REGFILE_ARB_STATS_EN
    logic [STAT_W-1:0] stat_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                stat_cnt[i] <= '0;
            end else if (req_v[i] && !grant[i] && (stat_cnt[i] != '1)) begin
                stat_cnt[i] <= stat_cnt[i] + 1'b1;
            end
        end
    end

    assign stat_jal_wait = stat_cnt[REQ_JAL];
    assign stat_ld_wait  = stat_cnt[REQ_LD];
    assign stat_alu_wait = stat_cnt[REQ_ALU];
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port among three writeback sources: JAL link write, load return, and ALU result. Accepts one request per cycle over valid/ready handshakes and presents a registered write (wr_en/wr_addr/wr_data) to the register file. Fixed priority with per-requester aging prevents starvation. Sits between the pipeline writeback/memory stages and the register file. Also replaces the register file's separate JumpAndLink side-port.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width
LINK_REG, 31, destination register for JAL link writes
AGE_MAX, 3, wait cycles after which a requester is promoted; counter saturates here

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
jal_valid  in  1  link write request
jal_ready  out  1  link request granted this cycle
jal_data  in  DATA_W  return address; destination fixed to LINK_REG
ld_valid  in  1  load writeback request
ld_ready  out  1  load request granted this cycle
ld_addr  in  ADDR_W  load destination register
ld_data  in  DATA_W  load data
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request granted this cycle
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
wr_en  out  1  register file write enable (registered)
wr_addr  out  ADDR_W  register file write address (registered)
wr_data  out  DATA_W  register file write data (registered)
stall  out  1  some valid requester not granted this cycle (combinational)

Behaviour:
- Reset (rst=1 at posedge): wr_en=0, wr_addr=0, wr_data=0, all age counters=0. All *_ready=0 while rst=1. A request pending when rst asserts is dropped; the requester re-presents it after reset.
- Handshake: transfer when valid&&ready. Requester holds valid, addr and data stable until ready. The arbiter never deasserts a grant mid-cycle. ready is combinational from the valids and the age counters.
- Grant: at most one ready per cycle.
  - Any requester with age==AGE_MAX (saturated) beats any unsaturated requester.
  - Among equals, base priority is JAL > LD > ALU.
  - No valid requester: no grant, stall=0.
- Age counter, per requester, updated each posedge:
  - valid && !ready: increment, saturating at AGE_MAX.
  - Granted, or valid=0: clear to 0.
- Output latency 1 cycle. On the posedge after a transfer:
  - wr_addr and wr_data are loaded with the granted address/data. JAL uses LINK_REG.
  - wr_en=1 unless the granted address is 0. A write to r0 still completes the handshake but wr_en=0.
  - With no transfer, wr_en=0 and wr_addr/wr_data hold their previous values.
- Back-to-back transfers are allowed every cycle, so throughput is 1 write per cycle.
- stall = (jal_valid&&!jal_ready) || (ld_valid&&!ld_ready) || (alu_valid&&!alu_ready).

Optional Feature:
REGFILE_ARB_STATS_EN.
- Defined: adds outputs stat_jal_wait, stat_ld_wait, stat_alu_wait, each 16 bits.
  - Each counts cycles its requester was valid but not ready.
  - Saturates at 16'hFFFF and clears on rst.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package regfile_pkg holds DATA_W, ADDR_W, LINK_REG and the requester index constants REQ_JAL=0, REQ_LD=1, REQ_ALU=2.
- Sub-module regfile_arb_age_ctr is the saturating age counter. Inputs: clk, rst, valid, granted. Outputs: saturated flag. Instantiated 3x.
- Grant logic and the output register stay in the top module.

Test Plan:
- rst held 2 cycles with all valids=1 -> all ready=0, wr_en=0, wr_addr=0, wr_data=0, counters 0.
- Single request: alu_valid=1, alu_addr=5, alu_data=32'hDEADBEEF -> alu_ready=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF.
- Same-cycle conflict: jal_valid=1 with jal_data=32'h00400010, plus ld_valid=1 with ld_addr=8.
  - Cycle 0: jal_ready=1, ld_ready=0, stall=1.
  - Next cycle: wr_addr=31, wr_data=32'h00400010.
  - Cycle 1: ld granted; the write to r8 appears the following cycle.
- Aging, AGE_MAX=3, all three valid continuously, JAL re-requests every cycle:
  - Cycles 0-2: JAL granted.
  - Cycle 3: LD granted (both LD and ALU saturated; LD wins on base priority).
  - Cycle 4: ALU granted over unsaturated JAL.
- r0 write: alu_valid=1, alu_addr=0 -> alu_ready=1; next cycle wr_en=0.
- Reset mid-operation: ld_valid held, rst asserted in the cycle its age reaches 2 -> ld_ready=0 during rst; after rst deasserts, age restarts from 0 and ld is granted when no higher-priority request is present.
